// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and small decode helpers shared by the
// VGA sync generator. Optional feature macro: VGA_RGB_REG_EN (registered
// sync/blank/colour outputs).
package vga_pkg;

   // Horizontal timing, in pixels
   localparam int unsigned H_DISPLAY = 32'd640;
   localparam int unsigned H_FRONT   = 32'd16;
   localparam int unsigned H_SYNC    = 32'd96;
   localparam int unsigned H_BACK    = 32'd48;

   // Vertical timing, in lines
   localparam int unsigned V_DISPLAY = 32'd480;
   localparam int unsigned V_FRONT   = 32'd10;
   localparam int unsigned V_SYNC    = 32'd2;
   localparam int unsigned V_BACK    = 32'd33;

   // Colour driven while blanked
   localparam logic [7:0] COLOR_NULL = 8'h00;

   // Width of the x/y count outputs
   localparam int unsigned CNT_W = 32'd11;

   // Inclusive range test used for the sync pulse windows
   function automatic logic in_range(input logic [10:0] val,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen: divide-by-two toggle producing the 25 MHz pixel strobe from the
// 50 MHz system clock. The strobe is the toggle register itself, so it is low
// in reset and first asserts on the first clk after reset release.
module vga_tick_gen (
   input  logic clk,
   input  logic reset,
   output logic pixel_tick
);

   logic toggle_r;

   // Toggle every clk; the high phase marks one pixel period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         toggle_r <= 1'b0;
      end else begin
         toggle_r <= ~toggle_r;
      end
   end

   assign pixel_tick = toggle_r;

endmodule

// File: rtl/vga_sync.sv
// vga_sync: 640x480 VGA timing generator. Holds the horizontal/vertical pixel
// counters, decodes sync and visible-area windows, and gates renderer colour.
// Optional feature macro: VGA_RGB_REG_EN -- when defined, hsync/vsync/video_on
// and rgb_out are registered on pixel ticks (one pixel late) to line up with a
// renderer that registers its colour; otherwise they are combinational.
// The timing parameters default to the vga_pkg constants; every total and
// sync bound is derived from them.
module vga_sync
   import vga_pkg::*;
#(
   parameter int unsigned H_DISPLAY_P = H_DISPLAY,
   parameter int unsigned H_FRONT_P   = H_FRONT,
   parameter int unsigned H_SYNC_P    = H_SYNC,
   parameter int unsigned H_BACK_P    = H_BACK,
   parameter int unsigned V_DISPLAY_P = V_DISPLAY,
   parameter int unsigned V_FRONT_P   = V_FRONT,
   parameter int unsigned V_SYNC_P    = V_SYNC,
   parameter int unsigned V_BACK_P    = V_BACK
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rgb_in,
   output logic [CNT_W-1:0]  x,
   output logic [CNT_W-1:0]  y,
   output logic              pixel_tick,
   output logic              video_on,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic [7:0]        rgb_out
);

   // Derived counter limits and window bounds
   localparam logic [10:0] H_MAX_C    = 11'(H_DISPLAY_P + H_FRONT_P + H_SYNC_P + H_BACK_P - 32'd1);
   localparam logic [10:0] V_MAX_C    = 11'(V_DISPLAY_P + V_FRONT_P + V_SYNC_P + V_BACK_P - 32'd1);
   localparam logic [10:0] HS_START_C = 11'(H_DISPLAY_P + H_FRONT_P);
   localparam logic [10:0] HS_END_C   = 11'(H_DISPLAY_P + H_FRONT_P + H_SYNC_P - 32'd1);
   localparam logic [10:0] VS_START_C = 11'(V_DISPLAY_P + V_FRONT_P);
   localparam logic [10:0] VS_END_C   = 11'(V_DISPLAY_P + V_FRONT_P + V_SYNC_P - 32'd1);
   localparam logic [10:0] H_VIS_C    = 11'(H_DISPLAY_P);
   localparam logic [10:0] V_VIS_C    = 11'(V_DISPLAY_P);

   logic        tick_s;
   logic [10:0] h_count_r;
   logic [10:0] v_count_r;
   logic        frame_start_r;
   logic        h_last_s;
   logic        v_last_s;
   logic        hsync_raw_s;
   logic        vsync_raw_s;
   logic        video_raw_s;
   logic [7:0]  rgb_raw_s;

   vga_tick_gen u_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .pixel_tick (tick_s)
   );

   // Treat anything at or past the last value as the wrap point so an upset
   // count can never run beyond the frame
   assign h_last_s = (h_count_r >= H_MAX_C);
   assign v_last_s = (v_count_r >= V_MAX_C);

   // Pixel/line counters: h advances per tick, v advances on h wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_count_r <= 11'd0;
         v_count_r <= 11'd0;
      end else if (tick_s) begin
         if (h_last_s) begin
            h_count_r <= 11'd0;
            if (v_last_s) begin
               v_count_r <= 11'd0;
            end else begin
               v_count_r <= v_count_r + 11'd1;
            end
         end else begin
            h_count_r <= h_count_r + 11'd1;
            v_count_r <= v_count_r;
         end
      end else begin
         h_count_r <= h_count_r;
         v_count_r <= v_count_r;
      end
   end

   // Frame strobe: high for the one clk following the wrap to (0,0)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= tick_s & h_last_s & v_last_s;
      end
   end

   // Raw sync/visible decodes and blank-gated colour for the current counts
   always_comb begin
      hsync_raw_s = ~in_range(h_count_r, HS_START_C, HS_END_C);
      vsync_raw_s = ~in_range(v_count_r, VS_START_C, VS_END_C);
      video_raw_s = (h_count_r < H_VIS_C) && (v_count_r < V_VIS_C);
      if (video_raw_s) begin
         rgb_raw_s = rgb_in;
      end else begin
         rgb_raw_s = COLOR_NULL;
      end
   end

`ifdef VGA_RGB_REG_EN
   logic       hsync_r;
   logic       vsync_r;
   logic       video_r;
   logic [7:0] rgb_r;

   // Pixel-delayed copies of the decodes and colour, loaded on ticks
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_r <= 1'b1;
         vsync_r <= 1'b1;
         video_r <= 1'b0;
         rgb_r   <= COLOR_NULL;
      end else if (tick_s) begin
         hsync_r <= hsync_raw_s;
         vsync_r <= vsync_raw_s;
         video_r <= video_raw_s;
         rgb_r   <= rgb_raw_s;
      end else begin
         hsync_r <= hsync_r;
         vsync_r <= vsync_r;
         video_r <= video_r;
         rgb_r   <= rgb_r;
      end
   end

   assign hsync    = hsync_r;
   assign vsync    = vsync_r;
   assign video_on = video_r;
   assign rgb_out  = rgb_r;
`else
   assign hsync    = hsync_raw_s;
   assign vsync    = vsync_raw_s;
   assign video_on = video_raw_s;
   // Colour is forced to black while reset is held, even though (0,0) is visible
   assign rgb_out  = reset ? rgb_raw_s : COLOR_NULL;
`endif

   assign x           = h_count_r;
   assign y           = v_count_r;
   assign pixel_tick  = tick_s;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed self-checking bench for vga_sync. Instance A uses the
// full 640x480 timing; instance B shortens only the vertical timing
// (4 visible, 2 front, 2 sync, 2 back lines) so whole frames fit in a short run.
module tb_vga_sync;

`ifdef VGA_RGB_REG_EN
   localparam bit REG_MODE = 1'b1;
`else
   localparam bit REG_MODE = 1'b0;
`endif

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        reset2 = 1'b0;
   logic [7:0]  rgb_in = 8'hD0;

   logic [10:0] x_a, y_a, x_b, y_b;
   logic        tick_a, von_a, hs_a, vs_a, fs_a;
   logic        tick_b, von_b, hs_b, vs_b, fs_b;
   logic [7:0]  rgb_a, rgb_b;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        tick;
      logic        hs;
      logic        vs;
      logic        von;
      logic        fs;
      logic [10:0] px;
   } exp_t;

   vga_sync u_dut_a (
      .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(x_a), .y(y_a),
      .pixel_tick(tick_a), .video_on(von_a), .hsync(hs_a), .vsync(vs_a),
      .frame_start(fs_a), .rgb_out(rgb_a)
   );

   vga_sync #(
      .V_DISPLAY_P(4), .V_FRONT_P(2), .V_SYNC_P(2), .V_BACK_P(2)
   ) u_dut_b (
      .clk(clk), .reset(reset2), .rgb_in(rgb_in), .x(x_b), .y(y_b),
      .pixel_tick(tick_b), .video_on(von_b), .hsync(hs_b), .vsync(vs_b),
      .frame_start(fs_b), .rgb_out(rgb_b)
   );

   always #10 clk = ~clk;

   // Expected outputs kk clks after reset release (sampled at negedge).
   // Each pixel lasts two clks; x = kk/2 mod 800. In registered mode the
   // decodes describe the previous pixel and read reset values until the
   // first tick edge loads them.
   function automatic exp_t expect_at(int kk, int vtot, int vdisp, int vs0, int vs1);
      exp_t e;
      int p, hq, vq;
      p      = kk / 2;
      e.x    = 11'(p % 800);
      e.y    = 11'((p / 800) % vtot);
      e.tick = ((kk % 2) == 1);
      e.fs   = (kk > 0) && ((kk % (1600 * vtot)) == 0);
      if (REG_MODE) begin
         p = p - 1;
      end
      if (p < 0) begin
         e.hs  = 1'b1;
         e.vs  = 1'b1;
         e.von = 1'b0;
         e.px  = 11'd0;
      end else begin
         hq    = p % 800;
         vq    = (p / 800) % vtot;
         e.hs  = !((hq >= 656) && (hq <= 751));
         e.vs  = !((vq >= vs0) && (vq <= vs1));
         e.von = (hq < 640) && (vq < vdisp);
         e.px  = 11'(hq);
      end
      return e;
   endfunction

   function automatic logic [7:0] rgb_fn(input logic [10:0] xx, input bit vary);
      logic [7:0] v;
      v = xx[7:0] ^ 8'h5A;
      return vary ? v : 8'hD0;
   endfunction

   task automatic test_reset();
      logic exp_von;
      exp_von = !REG_MODE;
      rgb_in  = 8'hD0;
      repeat (3) @(negedge clk);
      total += 8;
      if (x_a !== 11'd0)       begin bad++; $display("FAIL reset_x: got %0d want 0", x_a); end
      if (y_a !== 11'd0)       begin bad++; $display("FAIL reset_y: got %0d want 0", y_a); end
      if (tick_a !== 1'b0)     begin bad++; $display("FAIL reset_tick: got %b want 0", tick_a); end
      if (hs_a !== 1'b1)       begin bad++; $display("FAIL reset_hsync: got %b want 1", hs_a); end
      if (vs_a !== 1'b1)       begin bad++; $display("FAIL reset_vsync: got %b want 1", vs_a); end
      if (fs_a !== 1'b0)       begin bad++; $display("FAIL reset_frame_start: got %b want 0", fs_a); end
      if (rgb_a !== 8'h00)     begin bad++; $display("FAIL reset_rgb: got %h want 00", rgb_a); end
      if (von_a !== exp_von)   begin bad++; $display("FAIL reset_video_on: got %b want %b", von_a, exp_von); end
      reset = 1'b1;
      k     = 0;
      #1;
      total += 2;
      if (x_a !== 11'd0)       begin bad++; $display("FAIL release_x: got %0d want 0", x_a); end
      if (tick_a !== 1'b0)     begin bad++; $display("FAIL release_tick: got %b want 0", tick_a); end
   endtask

   // Two full lines with constant colour: counters, tick, hsync window, blanking
   task automatic test_lines();
      exp_t e;
      int   hs_low;
      hs_low = 0;
      rgb_in = 8'hD0;
      for (int i = 1; i <= 3200; i++) begin
         @(negedge clk);
         k++;
         e = expect_at(k, 525, 480, 490, 491);
         #1;
         total += 8;
         if (x_a !== e.x)       begin bad++; $display("FAIL line_x k=%0d: got %0d want %0d", k, x_a, e.x); end
         if (y_a !== e.y)       begin bad++; $display("FAIL line_y k=%0d: got %0d want %0d", k, y_a, e.y); end
         if (tick_a !== e.tick) begin bad++; $display("FAIL line_tick k=%0d: got %b want %b", k, tick_a, e.tick); end
         if (hs_a !== e.hs)     begin bad++; $display("FAIL line_hsync k=%0d x=%0d: got %b want %b", k, e.x, hs_a, e.hs); end
         if (vs_a !== e.vs)     begin bad++; $display("FAIL line_vsync k=%0d: got %b want %b", k, vs_a, e.vs); end
         if (von_a !== e.von)   begin bad++; $display("FAIL line_video_on k=%0d x=%0d: got %b want %b", k, e.x, von_a, e.von); end
         if (fs_a !== e.fs)     begin bad++; $display("FAIL line_frame_start k=%0d: got %b want %b", k, fs_a, e.fs); end
         if (rgb_a !== (e.von ? 8'hD0 : 8'h00))
            begin bad++; $display("FAIL line_rgb k=%0d x=%0d: got %h want %h", k, e.x, rgb_a, (e.von ? 8'hD0 : 8'h00)); end
         if ((i <= 1600) && (hs_a == 1'b0)) hs_low++;
      end
      total++;
      if (hs_low !== 192) begin bad++; $display("FAIL hsync_low_clks: got %0d want 192", hs_low); end
   endtask

   // Colour that follows x: rgb_out tracks rgb_in (one pixel late when registered)
   task automatic test_pattern();
      exp_t       e;
      logic [7:0] want;
      for (int i = 1; i <= 1600; i++) begin
         @(negedge clk);
         k++;
         e      = expect_at(k, 525, 480, 490, 491);
         rgb_in = rgb_fn(e.x, 1'b1);
         #1;
         want = e.von ? rgb_fn(e.px, 1'b1) : 8'h00;
         total += 2;
         if (rgb_a !== want)  begin bad++; $display("FAIL pattern_rgb k=%0d x=%0d: got %h want %h", k, e.x, rgb_a, want); end
         if (von_a !== e.von) begin bad++; $display("FAIL pattern_video_on k=%0d: got %b want %b", k, von_a, e.von); end
      end
      rgb_in = 8'hD0;
   endtask

   // Reset inside the hsync pulse, then check counting restarts from (0,0)
   task automatic test_reset_mid();
      exp_t e;
      logic exp_von;
      bit   found;
      exp_von = !REG_MODE;
      found   = 1'b0;
      for (int i = 0; i < 1600 && !found; i++) begin
         @(negedge clk);
         k++;
         e = expect_at(k, 525, 480, 490, 491);
         if (e.x == 11'd700) found = 1'b1;
      end
      #1;
      total += 2;
      if (x_a !== 11'd700) begin bad++; $display("FAIL mid_pre_x: got %0d want 700", x_a); end
      if (hs_a !== 1'b0)   begin bad++; $display("FAIL mid_pre_hsync: got %b want 0", hs_a); end
      reset = 1'b0;
      #1;
      total += 8;
      if (x_a !== 11'd0)     begin bad++; $display("FAIL mid_x: got %0d want 0", x_a); end
      if (y_a !== 11'd0)     begin bad++; $display("FAIL mid_y: got %0d want 0", y_a); end
      if (hs_a !== 1'b1)     begin bad++; $display("FAIL mid_hsync: got %b want 1", hs_a); end
      if (vs_a !== 1'b1)     begin bad++; $display("FAIL mid_vsync: got %b want 1", vs_a); end
      if (rgb_a !== 8'h00)   begin bad++; $display("FAIL mid_rgb: got %h want 00", rgb_a); end
      if (tick_a !== 1'b0)   begin bad++; $display("FAIL mid_tick: got %b want 0", tick_a); end
      if (fs_a !== 1'b0)     begin bad++; $display("FAIL mid_frame_start: got %b want 0", fs_a); end
      if (von_a !== exp_von) begin bad++; $display("FAIL mid_video_on: got %b want %b", von_a, exp_von); end
      repeat (3) @(negedge clk);
      total++;
      if (x_a !== 11'd0) begin bad++; $display("FAIL mid_hold_x: got %0d want 0", x_a); end
      reset = 1'b1;
      k     = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         k++;
         e = expect_at(k, 525, 480, 490, 491);
         #1;
         total += 4;
         if (x_a !== e.x)       begin bad++; $display("FAIL restart_x k=%0d: got %0d want %0d", k, x_a, e.x); end
         if (y_a !== e.y)       begin bad++; $display("FAIL restart_y k=%0d: got %0d want %0d", k, y_a, e.y); end
         if (tick_a !== e.tick) begin bad++; $display("FAIL restart_tick k=%0d: got %b want %b", k, tick_a, e.tick); end
         if (hs_a !== e.hs)     begin bad++; $display("FAIL restart_hsync k=%0d: got %b want %b", k, hs_a, e.hs); end
      end
   endtask

   // Whole frames on the short-vertical instance: vsync window, y=4 blanking,
   // frame_start once per 16000-clk frame
   task automatic test_frame();
      exp_t e;
      int   kb, fs_cnt, fs_first, fs_second, vs_low;
      fs_cnt = 0; fs_first = -1; fs_second = -1; vs_low = 0;
      rgb_in = 8'hD0;
      @(negedge clk);
      reset2 = 1'b1;
      kb     = 0;
      for (int i = 1; i <= 32100; i++) begin
         @(negedge clk);
         kb++;
         e = expect_at(kb, 10, 4, 6, 7);
         #1;
         total += 6;
         if (x_b !== e.x)     begin bad++; $display("FAIL frame_x k=%0d: got %0d want %0d", kb, x_b, e.x); end
         if (y_b !== e.y)     begin bad++; $display("FAIL frame_y k=%0d: got %0d want %0d", kb, y_b, e.y); end
         if (vs_b !== e.vs)   begin bad++; $display("FAIL frame_vsync k=%0d y=%0d: got %b want %b", kb, e.y, vs_b, e.vs); end
         if (von_b !== e.von) begin bad++; $display("FAIL frame_video_on k=%0d y=%0d: got %b want %b", kb, e.y, von_b, e.von); end
         if (fs_b !== e.fs)   begin bad++; $display("FAIL frame_start k=%0d: got %b want %b", kb, fs_b, e.fs); end
         if (rgb_b !== (e.von ? 8'hD0 : 8'h00))
            begin bad++; $display("FAIL frame_rgb k=%0d y=%0d: got %h want %h", kb, e.y, rgb_b, (e.von ? 8'hD0 : 8'h00)); end
         if (fs_b == 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = kb;
            else if (fs_second < 0) fs_second = kb;
         end
         if ((kb <= 16000) && (vs_b == 1'b0)) vs_low++;
      end
      total += 3;
      if (fs_cnt !== 2)                  begin bad++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt); end
      if ((fs_second - fs_first) !== 16000)
         begin bad++; $display("FAIL frame_period: got %0d want 16000", fs_second - fs_first); end
      if (vs_low !== 3200)               begin bad++; $display("FAIL vsync_low_clks: got %0d want 3200", vs_low); end
   endtask

   initial begin
      test_reset();
      test_lines();
      test_pattern();
      test_reset_mid();
      test_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
